cdm8_error_monitor: RTL

//  Hardware counterpart to the exhaustive multiplier bench. It sweeps every operand pair into an

---
 rtl/cdm_pkg.sv | 16 +
 rtl/cdm_err_accum.sv | 48 ++++
 rtl/cdm8_error_monitor.sv | 103 ++++++++++
 3 files changed

// File: rtl/cdm_pkg.sv
// rtl/cdm_pkg.sv - shared widths, drain length and state encoding for the cdm8 error monitor
package cdm_pkg;

    localparam int CDM_N        = 8;
    localparam int CDM_CW       = 2 * CDM_N + 1;
    localparam int CDM_SW       = 4 * CDM_N;
    localparam int DRAIN_CYCLES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } cdm_state_e;

endpackage

// File: rtl/cdm_err_accum.sv
// rtl/cdm_err_accum.sv - S2 stage: exact product, absolute error and running count/sum/max
module cdm_err_accum
    import cdm_pkg::*;
#(
    parameter int N  = CDM_N,
    parameter int CW = 2 * N + 1,
    parameter int SW = 4 * N
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            valid,
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
    input  logic [2*N-1:0]  approx,
    output logic [CW-1:0]   err_count,
    output logic [SW-1:0]   sum_abs_err,
    output logic [2*N-1:0]  max_abs_err,
    output logic [N-1:0]    max_a,
    output logic [N-1:0]    max_b
);

    logic [2*N-1:0] exact;
    logic [2*N-1:0] diff;

    assign exact = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    assign diff  = (approx >= exact) ? (approx - exact) : (exact - approx);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            err_count   <= '0;
            sum_abs_err <= '0;
            max_abs_err <= '0;
            max_a       <= '0;
            max_b       <= '0;
        end else if (valid) begin
            err_count   <= err_count + {{(CW-1){1'b0}}, (diff != '0)};
            sum_abs_err <= sum_abs_err + {{(SW-2*N){1'b0}}, diff};
            // strict compare keeps the earliest pair on ties
            if (diff > max_abs_err) begin
                max_abs_err <= diff;
                max_a       <= a;
                max_b       <= b;
            end
        end
    end

endmodule

// File: rtl/cdm8_error_monitor.sv
// rtl/cdm8_error_monitor.sv - sweeps all operand pairs through an external multiplier and gathers error statistics
module cdm8_error_monitor
    import cdm_pkg::*;
#(
    parameter int N  = CDM_N,
    parameter int CW = 2 * N + 1,
    parameter int SW = 4 * N
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [N-1:0]    op_a,
    output logic [N-1:0]    op_b,
    input  logic [2*N-1:0]  approx_r,
    output logic [CW-1:0]   err_count,
    output logic [SW-1:0]   sum_abs_err,
    output logic [2*N-1:0]  max_abs_err,
    output logic [N-1:0]    max_a,
    output logic [N-1:0]    max_b
);

    localparam logic [N-1:0] OP_MAX = {N{1'b1}};

    cdm_state_e     state;
    logic [1:0]     drain_cnt;
    logic           start_ok;
    logic [N-1:0]   s1_a;
    logic [N-1:0]   s1_b;
    logic [2*N-1:0] s1_r;
    logic           s1_v;

    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign busy     = (state == SWEEP) || (state == DRAIN);
    assign done     = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            drain_cnt <= '0;
            op_a      <= '0;
            op_b      <= '0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_r      <= '0;
            s1_v      <= 1'b0;
        end else if (start_ok) begin
            state     <= SWEEP;
            drain_cnt <= '0;
            op_a      <= '0;
            op_b      <= '0;
            s1_v      <= 1'b0;
        end else begin
            // approx_r is combinational from op_a/op_b, so it pairs with them this cycle
            s1_a <= op_a;
            s1_b <= op_b;
            s1_r <= approx_r;
            s1_v <= (state == SWEEP);
            case (state)
                SWEEP: begin
                    if (op_a == OP_MAX && op_b == OP_MAX) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else begin
                        op_b <= op_b + 1'b1;
                        if (op_b == OP_MAX) begin
                            op_a <= op_a + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 2'(DRAIN_CYCLES - 1)) begin
                        state <= DONE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    cdm_err_accum #(
        .N  (N),
        .CW (CW),
        .SW (SW)
    ) u_accum (
        .clk         (clk),
        .rst         (rst),
        .clear       (start_ok),
        .valid       (s1_v),
        .a           (s1_a),
        .b           (s1_b),
        .approx      (s1_r),
        .err_count   (err_count),
        .sum_abs_err (sum_abs_err),
        .max_abs_err (max_abs_err),
        .max_a       (max_a),
        .max_b       (max_b)
    );

endmodule
